// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : RV32I opcodes, encoder format enum and NOP word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd6
  } fmt_e;

  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    fmt_e fmt;
    case (opcode)
      c_op_reg:                         fmt = FMT_R;
      c_op_imm, c_op_load, c_op_jalr:   fmt = FMT_I;
      c_op_store:                       fmt = FMT_S;
      c_op_branch:                      fmt = FMT_B;
      c_op_lui, c_op_auipc:             fmt = FMT_U;
      c_op_jal:                         fmt = FMT_J;
      default:                          fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// ============================================================================
// Module      : imm_pack
// Description : Combinational RV32I field packer with immediate range check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_pack
  import rv_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_err
);

  fmt_e        w_fmt;
  logic [31:0] w_raw;
  logic        w_bad;
  logic        w_hi11_eq;
  logic        w_hi12_eq;
  logic        w_hi20_eq;

  // Sign-extension check: the dropped upper bits must all equal the kept sign bit.
  assign w_hi11_eq = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_hi12_eq = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_hi20_eq = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  always_comb begin
    w_fmt = decode_fmt(i_opcode);
    w_raw = 32'h0;
    w_bad = 1'b0;
    case (w_fmt)
      FMT_R: w_raw = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_bad = ~w_hi11_eq;
      end
      FMT_S: begin
        w_raw = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        w_bad = ~w_hi11_eq;
      end
      FMT_B: begin
        w_raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                 i_imm[4:1], i_imm[11], i_opcode};
        w_bad = ~w_hi12_eq | i_imm[0];
      end
      FMT_U: begin
        w_raw = {i_imm[31:12], i_rd, i_opcode};
        w_bad = |i_imm[11:0];
      end
      FMT_J: begin
        w_raw = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        w_bad = ~w_hi20_eq | i_imm[0];
      end
      default: w_bad = 1'b1;
    endcase
    o_err   = w_bad;
    o_instr = w_bad ? c_nop : w_raw;
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : RV32I instruction encoder with 2-entry output FIFO and counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  logic [31:0] w_enc_instr;
  logic        w_enc_err;
  logic        w_push;
  logic        w_pop;

  logic [1:0]  r_count;
  logic        r_wptr;
  logic        r_rptr;
  logic [31:0] r_mem_instr [2];
  logic        r_mem_err   [2];
  logic [15:0] r_enc_count;
  logic [15:0] r_err_count;

  imm_pack u_imm_pack (
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (in_imm),
    .o_instr  (w_enc_instr),
    .o_err    (w_enc_err)
  );

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_instr = out_valid ? r_mem_instr[r_rptr] : 32'h0;
  assign out_err   = out_valid ? r_mem_err[r_rptr]   : 1'b0;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_enc_count <= 16'h0;
      r_err_count <= 16'h0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wptr] <= w_enc_instr;
        r_mem_err[r_wptr]   <= w_enc_err;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        if (r_enc_count != 16'hFFFF) r_enc_count <= r_enc_count + 16'd1;
        if (out_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed table-driven bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [20];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_enc    = 0;
  int          m_err    = 0;
  logic [31:0] got [$];
  logic [31:0] bp_words [3];
  logic        took;

  function automatic vec_t mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] imm, logic [31:0] ei, logic ee);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  initial begin
    tbl[0]  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h00500093, 1'b0);
    tbl[1]  = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          32'h0020A423, 1'b0);
    tbl[2]  = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC,   32'hFE000EE3, 1'b0);
    tbl[3]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h001000EF, 1'b0);
    tbl[4]  = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,   32'h123452B7, 1'b0);
    tbl[5]  = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF,   32'h002081B3, 1'b0);
    tbl[6]  = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,          32'h402081B3, 1'b0);
    tbl[7]  = mk(7'h03, 5'd2, 5'd1, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFF,   32'hFFF0A103, 1'b0);
    tbl[8]  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800,   32'h80000093, 1'b0);
    tbl[9]  = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,       32'h7FF00093, 1'b0);
    tbl[10] = mk(7'h17, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000,   32'hFFFFF097, 1'b0);
    tbl[11] = mk(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001,   32'h00000013, 1'b1);
    tbl[12] = mk(7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'h00, 32'h0,          32'h00000013, 1'b1);
    tbl[13] = mk(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE,   32'hFFFFF06F, 1'b0);
    tbl[14] = mk(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000FFFFE,   32'h7FFFF06F, 1'b0);
    tbl[15] = mk(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000,   32'h00000013, 1'b1);
    tbl[16] = mk(7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h0,          32'h00008067, 1'b0);
    tbl[17] = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFF7FF,   32'h00000013, 1'b1);
    tbl[18] = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000,   32'h00000013, 1'b1);
    tbl[19] = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000FFE,   32'h7E000FE3, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0, 32'h0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err",   out_err, 0);
    chk("rst_enc_count", enc_count, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two back-to-back error words: second push coincides with first pop.
    @(negedge clk);
    out_ready = 1'b1;
    drive(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048, 32'h0, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("err1_instr", out_instr, 32'h00000013);
    chk("err1_err",   out_err, 1);
    @(negedge clk);
    drive(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3, 32'h0, 1'b0));
    @(posedge clk); #1;
    chk("err2_valid", out_valid, 1);
    chk("err2_instr", out_instr, 32'h00000013);
    chk("err2_err",   out_err, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    m_enc = 2; m_err = 2;
    chk("err_drain_valid", out_valid, 0);
    chk("err_enc_count",   enc_count, m_enc);
    chk("err_err_count",   err_count, m_err);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk($sformatf("v%0d_pre_valid", i), out_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_instr", i), out_instr, tbl[i].exp_instr);
      chk($sformatf("v%0d_err", i),   out_err, tbl[i].exp_err);
      m_enc++;
      if (tbl[i].exp_err) m_err++;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_drained", i), out_valid, 0);
      chk($sformatf("v%0d_enc_count", i), enc_count, m_enc);
      chk($sformatf("v%0d_err_count", i), err_count, m_err);
    end

    // Backpressure: three pushes with the consumer stalled.
    bp_words[0] = 32'h00100093;
    bp_words[1] = 32'h00200093;
    bp_words[2] = 32'h00300093;
    @(negedge clk);
    out_ready = 1'b0;
    drive(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1, 32'h0, 1'b0));
    in_valid = 1'b1;
    chk("bp_ready0", in_ready, 1);
    @(negedge clk);
    drive(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2, 32'h0, 1'b0));
    chk("bp_ready1", in_ready, 1);
    chk("bp_head1",  out_instr, bp_words[0]);
    @(negedge clk);
    drive(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3, 32'h0, 1'b0));
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head2",      out_instr, bp_words[0]);
    @(negedge clk);
    chk("bp_still_full", in_ready, 0);
    chk("bp_head3",      out_instr, bp_words[0]);
    chk("bp_valid",      out_valid, 1);
    out_ready = 1'b1;
    took = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      if (took) in_valid = 1'b0;
      if (out_valid && out_ready) got.push_back(out_instr);
      took = in_valid && in_ready;
      @(posedge clk);
    end
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), (k < got.size()) ? got[k] : 32'hXXXXXXXX, bp_words[k]);
    m_enc += 3;
    #1;
    chk("bp_enc_count", enc_count, m_enc);

    // Reset with two words buffered.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rr_full", in_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rr_valid",     out_valid, 0);
    chk("rr_enc_count", enc_count, 0);
    chk("rr_err_count", err_count, 0);
    chk("rr_in_ready",  in_ready, 1);
    chk("rr_instr",     out_instr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rr_nothing_out", out_valid, 0);
    chk("rr_enc_after",   enc_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use a single clock, clk, with synchronous active-low reset, rst_n, and SHALL have no parameters.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  request present
- in_ready  out  1  request can be accepted
- in_opcode  in  7  RV32I opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R-type only)
- in_imm  in  32  unscattered signed immediate (byte offset for B/J; full value for U)
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  1  word replaced due to encode error
- enc_count  out  16  words emitted, saturating
- err_count  out  16  error words emitted, saturating

Function
REQ-003 A transfer SHALL occur on in_valid&&in_ready (input) and on out_valid&&out_ready (output), each at a rising clk edge.
REQ-004 Format SHALL derive from in_opcode: R=0110011; I=0010011/0000011/1100111; S=0100011; B=1100011; U=0110111/0010111; J=1101111; any other opcode is an encode error.
REQ-005 Field placement SHALL be the inverse of the RV32I immediate extraction: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7]; U imm[31:12]->[31:12]; J imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12]; rd/rs1/rs2/funct3/funct7 at standard positions where the format defines them; unused fields zero.
REQ-006 Range check, error if violated: I/S in_imm[31:11] all equal; B in_imm[31:12] all equal and in_imm[0]=0; J in_imm[31:20] all equal and in_imm[0]=0; U in_imm[11:0]=0; R ignores in_imm.
REQ-007 On error, out_instr SHALL be 32'h00000013 (NOP) and out_err=1; otherwise out_err=0.
REQ-008 Encoding SHALL be combinational on the accepted request; the result SHALL be written into a 2-entry output FIFO on the accepting edge (latency 1: out_valid high in the cycle after acceptance when the FIFO was empty).
REQ-009 out_instr/out_err SHALL present the FIFO head and SHALL hold stable while out_valid&&!out_ready.
REQ-010 in_ready SHALL equal (FIFO count < 2); no combinational path from out_ready to in_ready.
REQ-011 Simultaneous push and pop SHALL leave count unchanged and preserve order; push at count 2 cannot occur; pop at count 0 cannot occur.
REQ-012 FIFO read/write pointers SHALL be 1 bit each and wrap 1->0.
REQ-013 On each output transfer, enc_count SHALL increment, and err_count SHALL also increment when out_err=1; both saturate at 16'hFFFF.

Reset
REQ-014 While rst_n=0 at a clk edge: FIFO count, pointers, enc_count, and err_count SHALL clear to 0; out_valid=0; in_ready=1 from the next cycle.
REQ-015 out_instr and out_err SHALL read 0 while the FIFO is empty.
REQ-016 Reset mid-operation SHALL discard buffered words without emitting them.

Structure
REQ-017 Opcode constants, the format enum (FMT_R/I/S/B/U/J/BAD), and the NOP constant SHALL reside in a shared package, rv_pkg.
REQ-018 The combinational encode/range-check logic SHALL be a sub-module, imm_pack; the FIFO and counters SHALL reside in instr_encoder.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- addi rd=1, rs1=0, f3=0, imm=5 -> 0x00500093, out_err=0, out_valid one cycle after acceptance.
- sw rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423; beq rs1=0, rs2=0, imm=-4 -> 0xFE000EE3.
- jal rd=1, imm=2048 -> 0x001000EF; lui rd=5, imm=0x12345000 -> 0x123452B7.
- addi imm=2048, then beq imm=3 -> two words 0x00000013 with out_err=1, err_count=2.
- out_ready=0 for 3 pushes -> in_ready drops after 2 accepted, head stable; then out_ready=1 with concurrent push -> in-order delivery, no loss.
- rst_n=0 with 2 buffered words -> out_valid=0 and both counts 0 next cycle; nothing emitted.
